chan_reconfig_ctrl: RTL and testbench

- Run-time reconfiguration sequencer for the M/2 channelizer datapath (input buffer -> PFB -> circular buffer -> xfft -> exponent shifter -> output framer).
- Accepts FFT-size change requests, halts input at a safe point and drains the pipeline.
- Holds the datapath in reset for a guaranteed width, then issues the xfft config word and releases input.
- Sits beside the channelizer top level and drives its core reset, active fft_size and FFT config channel.

---
 rtl/chan_ctrl_pkg.sv | 35 +++
 rtl/chan_size_decode.sv | 15 +
 rtl/chan_reconfig_ctrl.sv | 144 ++++++++++++++
 tb/tb_chan_reconfig_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/chan_ctrl_pkg.sv
// Shared definitions for the channelizer reconfiguration sequencer:
// FSM encoding, supported FFT size range and the size -> log2 helper.
package chan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_RESET  = 2'd2,
        ST_CONFIG = 2'd3
    } state_t;

    localparam int FFT_MIN      = 8;
    localparam int FFT_MAX      = 2048;
    localparam int DEFAULT_SIZE = 128;

    typedef struct packed {
        logic       valid;
        logic [4:0] nfft;
    } size_info_t;

    // Only exact powers of two inside [FFT_MIN, FFT_MAX] are legal.
    function automatic size_info_t size_to_nfft(input logic [11:0] size);
        size_info_t info;
        info.valid = 1'b0;
        info.nfft  = 5'd0;
        for (int k = $clog2(FFT_MIN); k <= $clog2(FFT_MAX); k++) begin
            if (size == 12'(1 << k)) begin
                info.valid = 1'b1;
                info.nfft  = 5'(k);
            end
        end
        return info;
    endfunction

endpackage

// File: rtl/chan_size_decode.sv
// Combinational legality check and log2 of a requested 12-bit FFT size.
module chan_size_decode (
    input  logic [11:0] size,
    output logic        legal,
    output logic [4:0]  nfft
);
    import chan_ctrl_pkg::*;

    size_info_t info;

    assign info  = size_to_nfft(size);
    assign legal = info.valid;
    assign nfft  = info.nfft;

endmodule

// File: rtl/chan_reconfig_ctrl.sv
// Run-time FFT-size reconfiguration sequencer: gates input, drains the
// pipeline, holds the datapath in reset, then issues the xfft config word.
module chan_reconfig_ctrl #(
    parameter int RESET_CYCLES = 16,
    parameter int DRAIN_CYCLES = 64,
    parameter int DEFAULT_SIZE = chan_ctrl_pkg::DEFAULT_SIZE
) (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic        cfg_req_valid,
    input  logic [11:0] cfg_req_size,
    output logic        cfg_req_ready,
    output logic        cfg_err,
    output logic        in_gate,
    input  logic        out_take,
    input  logic        out_tlast,
    output logic        core_reset,
    output logic [11:0] fft_size,
    output logic        fft_cfg_tvalid,
    output logic [15:0] fft_cfg_tdata,
    input  logic        fft_cfg_tready,
    output logic        busy
);
    import chan_ctrl_pkg::*;

    localparam int CNT_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam size_info_t DEFAULT_INFO = size_to_nfft(12'(DEFAULT_SIZE));

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [11:0]      pending_size;
    logic [4:0]       pending_nfft;
    logic [4:0]       nfft;
    logic             req_legal;
    logic [4:0]       req_nfft;
    logic             accept;
    logic             load_pending;
    logic             load_size;
    logic             err_next;

    chan_size_decode u_size_decode (
        .size  (cfg_req_size),
        .legal (req_legal),
        .nfft  (req_nfft)
    );

    assign accept        = cfg_req_valid & cfg_req_ready;
    assign fft_cfg_tdata = {11'b0, nfft};

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state <= ST_RESET;
            cnt   <= RESET_LAST;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The GATE idle counter and the RESET width counter share one register.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        load_pending = 1'b0;
        load_size    = 1'b0;
        err_next     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_legal) begin
                        err_next = 1'b1;
                    end else if (cfg_req_size != fft_size) begin
                        load_pending = 1'b1;
                        cnt_next     = '0;
                        state_next   = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if ((out_take && out_tlast) || (!out_take && cnt == DRAIN_LAST)) begin
                    load_size  = 1'b1;
                    cnt_next   = RESET_LAST;
                    state_next = ST_RESET;
                end else if (out_take) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RESET: begin
                if (cnt == '0) begin
                    state_next = ST_CONFIG;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_CONFIG: begin
                if (fft_cfg_tvalid && fft_cfg_tready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = RESET_LAST;
                state_next = ST_RESET;
            end
        endcase
    end

    // Outputs are registered copies of the next state, so they line up
    // with the state they describe without any combinational path out.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            pending_size   <= 12'(DEFAULT_SIZE);
            pending_nfft   <= DEFAULT_INFO.nfft;
            fft_size       <= 12'(DEFAULT_SIZE);
            nfft           <= DEFAULT_INFO.nfft;
            core_reset     <= 1'b1;
            in_gate        <= 1'b0;
            fft_cfg_tvalid <= 1'b0;
            cfg_req_ready  <= 1'b0;
            cfg_err        <= 1'b0;
            busy           <= 1'b1;
        end else begin
            if (load_pending) begin
                pending_size <= cfg_req_size;
                pending_nfft <= req_nfft;
            end
            if (load_size) begin
                fft_size <= pending_size;
                nfft     <= pending_nfft;
            end
            core_reset     <= (state_next == ST_RESET);
            in_gate        <= (state_next == ST_IDLE);
            fft_cfg_tvalid <= (state_next == ST_CONFIG);
            cfg_req_ready  <= (state_next == ST_IDLE);
            cfg_err        <= err_next;
            busy           <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_chan_reconfig_ctrl.sv
// Self-checking bench for chan_reconfig_ctrl: directed and random size
// requests checked against a size/latency model of the sequencer.
module tb_chan_reconfig_ctrl;

    localparam int RESET_CYCLES = 16;
    localparam int DRAIN_CYCLES = 64;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        cfg_req_valid;
    logic [11:0] cfg_req_size;
    logic        cfg_req_ready;
    logic        cfg_err;
    logic        in_gate;
    logic        out_take;
    logic        out_tlast;
    logic        core_reset;
    logic [11:0] fft_size;
    logic        fft_cfg_tvalid;
    logic [15:0] fft_cfg_tdata;
    logic        fft_cfg_tready;
    logic        busy;

    int tests = 0;
    int failures = 0;
    int cycle = 0;
    logic [11:0] model_size = 12'd128;

    chan_reconfig_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .DEFAULT_SIZE (128)
    ) dut (
        .clk            (clk),
        .sync_reset     (sync_reset),
        .cfg_req_valid  (cfg_req_valid),
        .cfg_req_size   (cfg_req_size),
        .cfg_req_ready  (cfg_req_ready),
        .cfg_err        (cfg_err),
        .in_gate        (in_gate),
        .out_take       (out_take),
        .out_tlast      (out_tlast),
        .core_reset     (core_reset),
        .fft_size       (fft_size),
        .fft_cfg_tvalid (fft_cfg_tvalid),
        .fft_cfg_tdata  (fft_cfg_tdata),
        .fft_cfg_tready (fft_cfg_tready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Datapath held in reset for the full width, then one config beat,
    // optionally back-pressured, then input released.
    task automatic expect_reset_then_config(input logic [4:0] exp_nfft,
                                            input logic [11:0] exp_size,
                                            input int bp);
        int n = 0;
        while (core_reset === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check_output("reset_width", n, RESET_CYCLES);
        check_output("cfg_tvalid", fft_cfg_tvalid, 1);
        check_output("cfg_tdata", fft_cfg_tdata, {11'b0, exp_nfft});
        check_output("cfg_size", fft_size, exp_size);
        for (int i = 0; i < bp; i++) begin
            check_output("bp_tvalid", fft_cfg_tvalid, 1);
            check_output("bp_tdata", fft_cfg_tdata, {11'b0, exp_nfft});
            check_output("bp_in_gate", in_gate, 0);
            check_output("bp_ready", cfg_req_ready, 0);
            tick();
        end
        fft_cfg_tready = 1'b1;
        tick();
        check_output("done_in_gate", in_gate, 1);
        check_output("done_busy", busy, 0);
        check_output("done_tvalid", fft_cfg_tvalid, 0);
    endtask

    // mode 0: idle pipeline, mode 1: live traffic ending on a tlast beat.
    task automatic apply_stimulus(input logic [11:0] size, input int mode, input int bp);
        bit         legal;
        int         acc;
        int         n;
        int         beats;
        logic [4:0] exp_nfft;
        legal = (size >= 12'd8) && (size <= 12'd2048) && ((size & (size - 12'd1)) == 12'd0);
        exp_nfft = 5'd0;
        for (int k = 0; k < 12; k++)
            if (size == (12'd1 << k)) exp_nfft = 5'(k);
        fft_cfg_tready = (bp == 0);
        out_take  = 1'b0;
        out_tlast = 1'b0;
        cfg_req_valid = 1'b1;
        cfg_req_size  = size;
        acc = cycle;
        check_output("req_ready", cfg_req_ready, 1);
        tick();
        cfg_req_valid = 1'b0;
        if (!legal) begin
            check_output("err_pulse", cfg_err, 1);
            check_output("err_busy", busy, 0);
            check_output("err_in_gate", in_gate, 1);
            check_output("err_size", fft_size, model_size);
            tick();
            check_output("err_clear", cfg_err, 0);
        end else if (size == model_size) begin
            check_output("same_err", cfg_err, 0);
            check_output("same_in_gate", in_gate, 1);
            check_output("same_busy", busy, 0);
            check_output("same_ready", cfg_req_ready, 1);
            check_output("same_size", fft_size, model_size);
        end else begin
            check_output("gate_in_gate", in_gate, 0);
            check_output("gate_busy", busy, 1);
            check_output("gate_ready", cfg_req_ready, 0);
            if (mode == 0) begin
                n = 0;
                while (core_reset !== 1'b1 && n < 200) begin
                    check_output("drain_size_hold", fft_size, model_size);
                    n++;
                    tick();
                end
                check_output("drain_len", n, DRAIN_CYCLES);
                check_output("drain_new_size", fft_size, size);
            end else begin
                beats = $urandom_range(4, 24);
                for (int i = 0; i < beats; i++) begin
                    out_take  = ($urandom_range(0, 2) != 0);
                    out_tlast = out_take ? 1'b0 : 1'($urandom_range(0, 1));
                    check_output("stream_size_hold", fft_size, model_size);
                    check_output("stream_no_reset", core_reset, 0);
                    tick();
                end
                out_take  = 1'b1;
                out_tlast = 1'b1;
                tick();
                out_take  = 1'b0;
                out_tlast = 1'b0;
                check_output("tlast_reset", core_reset, 1);
                check_output("tlast_size", fft_size, size);
            end
            model_size = size;
            expect_reset_then_config(exp_nfft, size, bp);
            if (mode == 0)
                check_output("latency", cycle - acc + 1, 1 + DRAIN_CYCLES + RESET_CYCLES + 2 + bp);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_core_reset", core_reset, 1);
        check_output("rst_in_gate", in_gate, 0);
        check_output("rst_tvalid", fft_cfg_tvalid, 0);
        check_output("rst_ready", cfg_req_ready, 0);
        check_output("rst_err", cfg_err, 0);
        check_output("rst_busy", busy, 1);
        check_output("rst_size", fft_size, 128);
    endtask

    initial begin
        logic [11:0] rsize;
        sync_reset     = 1'b1;
        cfg_req_valid  = 1'b0;
        cfg_req_size   = 12'd0;
        out_take       = 1'b0;
        out_tlast      = 1'b0;
        fft_cfg_tready = 1'b1;
        repeat (3) tick();
        check_reset_values();
        sync_reset = 1'b0;
        expect_reset_then_config(5'd7, 12'd128, 0);
        check_output("pwr_size", fft_size, 128);

        apply_stimulus(12'd100, 0, 0);
        apply_stimulus(12'd128, 0, 0);
        apply_stimulus(12'd512, 1, 0);
        apply_stimulus(12'd2048, 0, 0);
        apply_stimulus(12'd64, 1, 50);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1)
                rsize = 12'd1 << $urandom_range(3, 11);
            else
                rsize = 12'($urandom_range(0, 4095));
            apply_stimulus(rsize, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Abort a sequence in GATE; pending size is discarded.
        if (model_size == 12'd1024) apply_stimulus(12'd256, 0, 0);
        fft_cfg_tready = 1'b1;
        cfg_req_valid  = 1'b1;
        cfg_req_size   = 12'd1024;
        tick();
        cfg_req_valid = 1'b0;
        repeat (10) tick();
        check_output("abort_in_gate_pre", in_gate, 0);
        sync_reset = 1'b1;
        #1;
        check_reset_values();
        tick();
        tick();
        sync_reset = 1'b0;
        model_size = 12'd128;
        expect_reset_then_config(5'd7, 12'd128, 0);
        check_output("abort_final_size", fft_size, 128);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
